// File: rtl/image_addr_gen_if.sv
// Strobe and status bundle between the instruction control unit (master) and image_addr_gen (slave).
// ADDR_W and CNT_W must match the parameters of the attached image_addr_gen.
interface image_addr_gen_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              im_rd;
  logic              im_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  rd_count;
  logic [CNT_W-1:0]  wr_count;
  logic              busy;
  logic              rd_wrap;
  logic              frame_done;
  logic              rd_overrun;

  modport master (
    output start, im_rd, im_we,
    input  rd_addr, wr_addr, rd_count, wr_count, busy, rd_wrap, frame_done, rd_overrun
  );

  modport slave (
    input  start, im_rd, im_we,
    output rd_addr, wr_addr, rd_count, wr_count, busy, rd_wrap, frame_done, rd_overrun
  );
endinterface

// File: rtl/image_addr_gen.sv
// Registered raw-image read / processed-image write address counters with IDLE/RUN/DONE frame tracking.
// Optional feature: define IMG_ADDR_OVERRUN_GUARD_EN to block reads past a full frame and flag rd_overrun.
module image_addr_gen #(
  parameter int ADDR_W    = 32,
  parameter int STEP      = 4,
  parameter int IMG_BYTES = 152100,
  parameter int CNT_W     = 16
) (
  input logic             clk,
  input logic             rst,
  image_addr_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - STEP);
  localparam logic [ADDR_W-1:0] STEP_A    = ADDR_W'(STEP);
  localparam logic [CNT_W-1:0]  WORDS     = CNT_W'(IMG_BYTES / STEP);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic              rd_wrap_q, rd_wrap_d;

  logic in_run, rd_last, wr_last, rd_full, rd_accept, wr_accept, clear;

  assign in_run    = (state_q == RUN);
  assign clear     = (state_q == IDLE) && bus.start;
  assign rd_last   = (rd_addr_q == LAST_ADDR);
  assign wr_last   = (wr_addr_q == LAST_ADDR);
  assign rd_full   = (rd_count_q == WORDS);
  assign wr_accept = in_run && bus.im_we;

`ifdef IMG_ADDR_OVERRUN_GUARD_EN
  logic overrun_q, overrun_d, rd_block;
  assign rd_accept = in_run && bus.im_rd && !rd_full;
  assign rd_block  = in_run && bus.im_rd && rd_full;
`else
  assign rd_accept = in_run && bus.im_rd;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (bus.im_we && wr_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q == RUN);
    bus.frame_done = (state_q == DONE);
  end

  always_comb begin
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    rd_wrap_d  = 1'b0;
    if (clear) begin
      rd_addr_d  = '0;
      wr_addr_d  = '0;
      rd_count_d = '0;
      wr_count_d = '0;
    end
    if (rd_accept) begin
      rd_addr_d = rd_last ? '0 : rd_addr_q + STEP_A;
      rd_wrap_d = rd_last;
      if (!rd_full) rd_count_d = rd_count_q + CNT_W'(1);
    end
    // Final write moves the FSM to DONE, so wr_count can never pass WORDS.
    if (wr_accept) begin
      wr_addr_d  = wr_last ? '0 : wr_addr_q + STEP_A;
      wr_count_d = wr_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      rd_wrap_q  <= 1'b0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      rd_wrap_q  <= rd_wrap_d;
    end
  end

`ifdef IMG_ADDR_OVERRUN_GUARD_EN
  always_comb begin
    overrun_d = overrun_q;
    if (clear)    overrun_d = 1'b0;
    if (rd_block) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign bus.rd_overrun = overrun_q;
`else
  assign bus.rd_overrun = 1'b0;
`endif

  assign bus.rd_addr  = rd_addr_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.rd_count = rd_count_q;
  assign bus.wr_count = wr_count_q;
  assign bus.rd_wrap  = rd_wrap_q;

endmodule

// File: doc/image_addr_gen.md
# image_addr_gen

Registered address generator for the raw-image read port and processed-image write port. It sits directly downstream of the instruction control unit and consumes its per-instruction image strobes: `im_rd` for LDR from the raw image and `im_we` for STR to the processed image. It replaces combinational address bumping with proper counters. Each counter steps by one 32-bit word per strobe, wraps at the frame boundary, and the block tracks frame progress through a small state machine.

## Interface
Parameters:
- `ADDR_W`, 32: width of both address outputs.
- `STEP`, 4: byte increment per access.
- `IMG_BYTES`, 152100: frame size in bytes (390×390 pixels, 38025 words). Must be a multiple of `STEP`.
- `CNT_W`, 16: width of the word counters.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begins a frame; sampled only in IDLE.
- `im_rd`, in, 1: raw-image read strobe from the control unit.
- `im_we`, in, 1: processed-image write strobe from the control unit.
- `rd_addr`, out, `ADDR_W`: current raw-image read byte address.
- `wr_addr`, out, `ADDR_W`: current processed-image write byte address.
- `rd_count`, out, `CNT_W`: words read in the current frame.
- `wr_count`, out, `CNT_W`: words written in the current frame.
- `busy`, out, 1: high in RUN.
- `rd_wrap`, out, 1: one-cycle pulse when `rd_addr` wraps to 0.
- `frame_done`, out, 1: one-cycle pulse, high in DONE.
- `rd_overrun`, out, 1: sticky read-overrun flag (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Strobes are ignored and the counters hold.
  - When `start`=1, go to RUN. On the same edge, clear `rd_addr`, `wr_addr`, `rd_count`, `wr_count` and `rd_overrun`.
- RUN:
  - `im_rd`=1 advances `rd_addr` by `STEP` and increments `rd_count`.
  - `im_we`=1 advances `wr_addr` by `STEP` and increments `wr_count`.
  - Both strobes in the same cycle advance both counters independently.
  - The address used by the current access is the pre-increment value.
- Read wrap:
  - If `rd_addr` = `IMG_BYTES-STEP` and `im_rd`=1, `rd_addr` becomes 0.
  - `rd_count` saturates at `IMG_BYTES/STEP`.
  - `rd_wrap` pulses on the next cycle.
  - The state remains RUN.
- Write completion:
  - If `wr_addr` = `IMG_BYTES-STEP` and `im_we`=1, `wr_addr` becomes 0 and `wr_count` reaches `IMG_BYTES/STEP`.
  - The state goes to DONE.
- DONE:
  - Lasts exactly one cycle with `frame_done`=1, then returns to IDLE.
  - Strobes are ignored.
  - `start` in DONE is ignored.
- `start` in RUN is ignored; no restart mid-frame.
- Counters hold their final values in IDLE until the next `start`.
- Arithmetic:
  - Address adders are `ADDR_W` wide; the compare is against the constant `IMG_BYTES-STEP`.
  - No address exceeds `IMG_BYTES-STEP`.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: state IDLE; `rd_addr`=0, `wr_addr`=0, `rd_count`=0, `wr_count`=0; `busy`=0, `rd_wrap`=0, `frame_done`=0, `rd_overrun`=0.
- Latency:
  - A strobe sampled at edge N produces the updated address visible after edge N.
  - `busy` rises the cycle after `start` is sampled.
  - `frame_done` is high the cycle after the final write is sampled; `busy` falls on that same edge.
- Reset asserted mid-frame returns all state to reset values immediately, asynchronously. The first edge after deassertion sees IDLE.
- The control unit holds each strobe for exactly one cycle per instruction. A strobe held for k cycles counts as k accesses.

## Configuration
- Macro: `IMG_ADDR_OVERRUN_GUARD_EN`.
- Defined:
  - A read strobe arriving when `rd_count` = `IMG_BYTES/STEP` is blocked: `rd_addr` and `rd_count` hold and `rd_wrap` does not pulse.
  - `rd_overrun` sets and stays high until `rst` or the next accepted `start`.
  - The wrap from `IMG_BYTES-STEP` to 0 on the last legal read still occurs.
- Undefined:
  - Reads keep wrapping freely.
  - `rd_overrun` is tied to 0.

## Test plan
- Reset then idle strobes: pulse `im_rd` and `im_we` for 5 cycles in IDLE -> `rd_addr`=0, `wr_addr`=0, `busy`=0.
- Basic stepping: `start`, then 3 `im_rd` and 2 `im_we` on separate cycles -> `rd_addr`=12, `rd_count`=3, `wr_addr`=8, `wr_count`=2.
- Simultaneous strobes: `im_rd` and `im_we` together for 10 cycles -> `rd_addr`=40 and `wr_addr`=40.
- Read wrap: 38025 reads -> `rd_addr`=0, `rd_wrap` pulse 1 cycle, `busy`=1. A 38026th read gives `rd_addr`=4 with the guard undefined; with the guard defined it gives `rd_addr`=0 and `rd_overrun`=1.
- Frame completion: 38025 writes -> `frame_done`=1 for exactly 1 cycle, `wr_count`=38025, IDLE on the next cycle. A `start` during DONE is ignored.
- Mid-frame reset: after 100 writes assert `rst` asynchronously between edges -> all outputs 0 immediately. A following `start` restarts at address 0.
